// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter.
// FSM state and owner encodings used by the top and the grant logic.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DBG = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way grant logic for the memory port arbiter.
// Ports: cpu_req/dbg_req in, grant_en (IDLE), update+done_owner (DONE),
// grant_valid/grant out. Holds the round-robin last_owner register.
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
#(
  parameter int DBG_PRIO = 0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   cpu_req,
  input  logic   dbg_req,
  input  logic   grant_en,
  input  logic   update,
  input  owner_t done_owner,
  output logic   grant_valid,
  output owner_t grant
);

  owner_t last_owner;

  // Resets to DBG so the CPU takes the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= OWNER_DBG;
    end else if (update) begin
      last_owner <= done_owner;
    end
  end

  always_comb begin
    grant = OWNER_CPU;
    if (cpu_req && dbg_req) begin
      if (DBG_PRIO != 0) begin
        grant = OWNER_DBG;
      end else begin
        grant = (last_owner == OWNER_CPU) ? OWNER_DBG : OWNER_CPU;
      end
    end else if (dbg_req) begin
      grant = OWNER_DBG;
    end
  end

  assign grant_valid = grant_en && (cpu_req || dbg_req);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified memory between the CPU and debug port.
// Ports: cpu_*/dbg_* requester sides (req/we/addr/wdata in, rdata/ack
// out), mem_* macro side (en/we/addr/wdata out, rdata in); clk, rst.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LATENCY      = 2,
  parameter int DBG_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  state_t        state;
  owner_t        owner;
  logic          we;
  logic [CW-1:0] cnt;
  logic          grant_valid;
  owner_t        grant;

  rr_arbiter2 #(
    .DBG_PRIO(DBG_PRIORITY)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .dbg_req    (dbg_req),
    .grant_en   (state == IDLE),
    .update     (state == DONE),
    .done_owner (owner),
    .grant_valid(grant_valid),
    .grant      (grant)
  );

  // mem_addr/mem_wdata double as the latched request; they load
  // on the IDLE->ACCESS edge and hold until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWNER_CPU;
      we        <= 1'b0;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
    end else begin
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            owner  <= grant;
            mem_en <= 1'b1;
            state  <= ACCESS;
            if (grant == OWNER_DBG) begin
              we        <= dbg_we;
              mem_we    <= dbg_we;
              mem_addr  <= dbg_addr;
              mem_wdata <= dbg_wdata;
            end else begin
              we        <= cpu_we;
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end
          end
        end
        ACCESS: begin
          cnt   <= CNT_LOAD;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= DONE;
            if (owner == OWNER_DBG) begin
              dbg_ack <= 1'b1;
              if (!we) dbg_rdata <= mem_rdata;
            end else begin
              cpu_ack <= 1'b1;
              if (!we) cpu_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory of the multi-cycle CPU between two requesters: the CPU controller (fetch/load/store) and the debug/program-loader port.
- Arbitrates between the two, issues exactly one memory access per grant, and waits a fixed memory latency.
- Returns a registered one-cycle ack plus read data to the winning requester.
- Sits between the CPU/loader and the memory macro.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LATENCY, 2, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.
- DBG_PRIORITY, 0, 0 = round-robin between requesters; 1 = debug port wins every tie.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  access address.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data, valid when cpu_ack is high, held until the next CPU read completes.
- cpu_ack  out  1  one-cycle completion pulse.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack: same as the cpu_* ports, for the debug port.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset: state IDLE; all outputs 0, including both rdata registers, mem_addr and mem_wdata. Round-robin last_owner resets to DBG, so the CPU wins the first tie.
- A reset asserted mid-transaction aborts it: no ack is issued and mem_en deasserts the next cycle. The requester must reissue.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - If any req is high, select the winner and latch owner, we, addr and wdata into internal registers. Next state ACCESS.
  - Otherwise remain in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_en = 1; mem_we = latched we; mem_addr and mem_wdata = latched values.
  - Load the wait counter with LATENCY-1. Next state WAIT.
- WAIT (exactly LATENCY cycles):
  - mem_en = 0; the counter decrements each cycle.
  - When the counter is 0, capture mem_rdata into the owner's rdata register (reads only; writes leave rdata unchanged). Pulse that owner's ack. Next state DONE.
- DONE (1 cycle):
  - Owner's ack = 1. Update last_owner to the owner.
  - Both reqs are ignored in this cycle. Next state IDLE.
- Timing: if req is first sampled in IDLE at cycle c, then ACCESS is at c+1 and ack is at c+LATENCY+2. With LATENCY = 2 each transaction occupies 5 cycles.
- Requester protocol:
  - Hold req, we, addr and wdata stable until ack.
  - In the cycle after ack, either drop req or present the next request; it is sampled in that IDLE cycle.
  - Dropping req before ack is a protocol violation. The latched transaction still completes and ack still pulses.
- Arbitration:
  - Single requester: it wins.
  - Both requesting, DBG_PRIORITY = 0: the requester not equal to last_owner wins.
  - Both requesting, DBG_PRIORITY = 1: dbg wins, and CPU starvation is accepted.
- Outputs:
  - mem_we is never high without mem_en.
  - Only one ack is high in any cycle; acks are never high outside DONE.
- Addresses are passed through unchecked; no alignment or range checks.
- Counter width is clog2(LATENCY+1).

Decomposition:
- Shared include file mem_arb_defs.vh holds:
  - State encodings: IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, DONE = 2'd3.
  - Owner encodings: OWNER_CPU = 1'b0, OWNER_DBG = 1'b1.
- One sub-module, rr_arbiter2: 2-way grant logic with the last_owner register, a fixed-priority parameter, and a grant-enable input driven in IDLE.

Test Plan:
- CPU read alone, LATENCY = 2: cpu_addr = 0x00000010, memory model returns 0x12345678 → mem_en high only in cycle 1 with mem_addr = 0x10 and mem_we = 0; cpu_ack pulses in cycle 4 with cpu_rdata = 0x12345678; dbg_ack stays 0.
- Both reqs raised in cycle 0 after reset, DBG_PRIORITY = 0, both held → CPU acked in cycle 4, dbg acked in cycle 9; a third transaction goes to the CPU, acked in cycle 14.
- DBG_PRIORITY = 1, both reqs held continuously for 30 cycles → dbg acked in cycles 4, 9, 14, …; cpu_ack never asserts.
- dbg write, dbg_addr = 0x40, dbg_wdata = 0xDEADBEEF → one cycle with mem_en = mem_we = 1 and those values; dbg_ack in cycle 4; dbg_rdata unchanged. A following CPU read of 0x40 returns 0xDEADBEEF.
- rst asserted during WAIT → the next cycle has state IDLE, mem_en = 0, both acks 0 and both rdata registers 0; no late ack follows.
- LATENCY = 1, CPU req held with a new address presented in the ack cycle → second ACCESS occurs 2 cycles after the first ack, carrying the new address; acks 4 cycles apart; no duplicate of the first access.
